// File: rtl/meter_pkg.sv
// Shared types and helpers for the multi-channel peak meter.
package meter_pkg;

    localparam int SAMPLE_W     = 24;
    localparam int MAG_W        = SAMPLE_W - 1;
    localparam int LED_N        = 8;
    localparam int LED_BASE_BIT = 15;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [MAG_W-1:0]           mag_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } meter_state_e;

    localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Saturating magnitude: the most negative code folds onto positive full scale.
    function automatic mag_t abs_sat(input sample_t x);
        sample_t neg;
        neg = -x;
        if (x == SAMPLE_MIN) begin
            return {MAG_W{1'b1}};
        end
        if (x[SAMPLE_W-1]) begin
            return neg[MAG_W-1:0];
        end
        return x[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/meter_bar.sv
// Magnitude to 8-LED thermometer, 6 dB (one bit position) per LED.
module meter_bar
    import meter_pkg::*;
(
    input  logic [MAG_W-1:0] mag_i,
    output logic [LED_N-1:0] bar_o
);

    // LED k lights once the magnitude reaches 2^(LED_BASE_BIT+k); monotonic by construction.
    always_comb begin
        bar_o = '0;
        for (int k = 0; k < LED_N; k++) begin
            bar_o[k] = (mag_i >= (mag_t'(1) << (LED_BASE_BIT + k)));
        end
    end

endmodule

// File: rtl/peak_meter.sv
// Multi-channel peak meter with hold and exponential decay.
// A frame_strobe in IDLE snapshots audio_bus and starts a scan that updates
// one channel per clock through a single shared compare/decay datapath.
// A strobe seen while scanning is dropped and reported on overrun.
// Optional sticky clip flags: define PEAK_METER_CLIP_LATCH_EN.
module peak_meter
    import meter_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int HOLD_FRAMES  = 24000,
    parameter int DECAY_SHIFT  = 10,
    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   frame_strobe,
    input  logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0]  audio_bus,
    input  logic [IDX_W-1:0]                       sel,
    input  logic                                   clear_clip,
    output logic [LED_N-1:0]                       led,
    output logic [NUM_CHANNELS-1:0]               clip,
    output logic                                   busy,
    output logic                                   overrun,
    output meter_state_e                           dbg_state
);

    meter_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  snap_en;
    logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0] snap_q;
    logic                                  overrun_q, overrun_d;
    logic [LED_N-1:0]                      led_q, led_d;

    mag_t              peak_q [NUM_CHANNELS];
    logic [HOLD_W-1:0] hold_q [NUM_CHANNELS];

    mag_t              cur_mag, cur_peak, dec, peak_d;
    logic [HOLD_W-1:0] cur_hold, hold_d;

    // Scan sequencer: next state, channel index and snapshot enable.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_strobe) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    snap_en = 1'b1;
                end
            end
            ST_SCAN: begin
                if (idx_q == IDX_W'(NUM_CHANNELS - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        overrun_d = frame_strobe && (state_q == ST_SCAN);
    end

    // Sequencer, snapshot and overrun registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            if (snap_en) begin
                snap_q <= audio_bus;
            end
        end
    end

    // Shared peak/hold update for the channel under the scan index.
    always_comb begin
        cur_mag  = abs_sat(sample_t'(snap_q[idx_q]));
        cur_peak = peak_q[idx_q];
        cur_hold = hold_q[idx_q];
        dec      = cur_peak >> DECAY_SHIFT;
        if (dec == '0) begin
            dec = mag_t'(1);
        end
        peak_d = cur_peak;
        hold_d = cur_hold;
        if (cur_mag > cur_peak) begin
            peak_d = cur_mag;
            hold_d = HOLD_W'(HOLD_FRAMES);
        end else if (cur_hold != '0) begin
            hold_d = cur_hold - HOLD_W'(1);
        end else if (cur_peak != '0) begin
            peak_d = (cur_peak > dec) ? (cur_peak - dec) : '0;
        end
    end

    // Per-channel peak and hold storage, written only during the channel's scan slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                peak_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else if (state_q == ST_SCAN) begin
            peak_q[idx_q] <= peak_d;
            hold_q[idx_q] <= hold_d;
        end
    end

    meter_bar u_bar (
        .mag_i (peak_q[sel]),
        .bar_o (led_d)
    );

    // Registered LED bar for the selected channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

`ifdef PEAK_METER_CLIP_LATCH_EN
    logic [NUM_CHANNELS-1:0] clip_q, clip_d;

    // Clear first, then a full-scale hit in this slot sets its flag, so set wins.
    always_comb begin
        clip_d = clear_clip ? '0 : clip_q;
        if ((state_q == ST_SCAN) && (cur_mag == {MAG_W{1'b1}})) begin
            clip_d[idx_q] = 1'b1;
        end
    end

    // Sticky clip flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip = clip_q;
`else
    logic unused_clear_clip;
    assign unused_clear_clip = clear_clip;
    assign clip = '0;
`endif

    assign led       = led_q;
    assign busy      = (state_q == ST_SCAN);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_peak_meter.sv
// Self-checking bench for peak_meter against a frame-level reference model.
// Honours PEAK_METER_CLIP_LATCH_EN when deciding the expected clip flags.
module tb_peak_meter;
    import meter_pkg::*;

    localparam int NCH  = 8;
    localparam int HOLD = 3;
    localparam int DSH  = 10;
    localparam int FS   = 8388607;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      frame_strobe = 1'b0;
    logic                      clear_clip = 1'b0;
    logic [NCH-1:0][23:0]      audio_bus = '0;
    logic [2:0]                sel = '0;
    logic [7:0]                led;
    logic [NCH-1:0]            clip;
    logic                      busy;
    logic                      overrun;
    meter_state_e              dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    int m_peak [NCH];
    int m_hold [NCH];
    bit m_clip [NCH];
    int drv    [NCH];

    logic [31:0] exp_q[$];

    peak_meter #(
        .NUM_CHANNELS (NCH),
        .HOLD_FRAMES  (HOLD),
        .DECAY_SHIFT  (DSH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_strobe (frame_strobe),
        .audio_bus    (audio_bus),
        .sel          (sel),
        .clear_clip   (clear_clip),
        .led          (led),
        .clip         (clip),
        .busy         (busy),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mag_of(input int x);
        int m;
        m = (x < 0) ? -x : x;
        if (m > FS) m = FS;
        return m;
    endfunction

    function automatic logic [7:0] bar_of(input int p);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (p >= (1 << (15 + k)));
        return b;
    endfunction

    function automatic logic [NCH-1:0] clip_exp();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = m_clip[c];
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_peak[c] = 0;
            m_hold[c] = 0;
            m_clip[c] = 1'b0;
        end
    endtask

    // One frame of the meter rules, channels in scan order.
    task automatic model_frame(input int clear_slot);
        int mag;
        int d;
        for (int c = 0; c < NCH; c++) begin
            mag = mag_of(drv[c]);
            if (c == clear_slot) begin
                for (int j = 0; j < NCH; j++) m_clip[j] = 1'b0;
            end
            if (mag > m_peak[c]) begin
                m_peak[c] = mag;
                m_hold[c] = HOLD;
            end else if (m_hold[c] != 0) begin
                m_hold[c] = m_hold[c] - 1;
            end else if (m_peak[c] != 0) begin
                d = m_peak[c] >> DSH;
                if (d < 1) d = 1;
                m_peak[c] = m_peak[c] - d;
                if (m_peak[c] < 0) m_peak[c] = 0;
            end
`ifdef PEAK_METER_CLIP_LATCH_EN
            if (mag == FS) m_clip[c] = 1'b1;
`endif
        end
    endtask

    task automatic sweep(input string tag);
        for (int c = 0; c < NCH; c++) begin
            sel = 3'(c);
            exp_q.push_back(32'(bar_of(m_peak[c])));
            tick();
            chk({tag, "_led"}, 32'(led), exp_q.pop_front());
            chk({tag, "_peak"}, 32'(dut.peak_q[c]), 32'(m_peak[c]));
        end
        chk({tag, "_clip"}, 32'(clip), 32'(clip_exp()));
    endtask

    // Strobe one frame from drv[], scramble the bus during the scan, check busy window.
    task automatic run_frame(input string tag, input int clear_slot, input bit do_sweep);
        for (int c = 0; c < NCH; c++) audio_bus[c] = 24'(drv[c]);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        for (int c = 0; c < NCH; c++) audio_bus[c] = 24'($urandom);
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        for (int c = 0; c < NCH; c++) begin
            clear_clip = (c == clear_slot);
            tick();
            clear_clip = 1'b0;
            if (c == NCH - 1) chk({tag, "_busy_end"}, 32'(busy), 32'd0);
            else if (c == 3) chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
        end
        chk({tag, "_no_overrun"}, 32'(overrun), 32'd0);
        model_frame(clear_slot);
        if (do_sweep) sweep(tag);
    endtask

    task automatic zero_drv();
        for (int c = 0; c < NCH; c++) drv[c] = 0;
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return int'($urandom_range(0, 70000)) - 35000;
            2: return int'($urandom_range(0, 16777215)) - 8388608;
            3: return ($urandom_range(0, 1) == 1) ? FS : -8388608;
            default: return -FS;
        endcase
    endfunction

    initial begin
        int clear_slot;
        model_reset();
        zero_drv();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b1;
        tick();

        // all-zero frame
        run_frame("zero", -1, 1'b1);

        // hold then decay on channel 2
        drv[2] = 32'h400000;
        run_frame("hold_set", -1, 1'b1);
        drv[2] = 0;
        for (int f = 0; f < 6; f++) run_frame("hold_decay", -1, 1'b1);

        // negative full scale on channel 5, then clear
        drv[5] = -8388608;
        run_frame("fs_neg", -1, 1'b1);
        drv[5] = 0;
        clear_clip = 1'b1;
        tick();
        clear_clip = 1'b0;
        for (int c = 0; c < NCH; c++) m_clip[c] = 1'b0;
        chk("clear_clip", 32'(clip), 32'd0);

        // clear landing on channel 5's slot while channels 1 and 5 clip
        zero_drv();
        drv[1] = FS;
        drv[5] = -FS;
        run_frame("clr_vs_set", 5, 1'b1);
        zero_drv();

        // strobe while busy: dropped, scan keeps first-frame data
        for (int c = 0; c < NCH; c++) begin
            drv[c] = int'($urandom_range(0, 4000)) - 2000;
            audio_bus[c] = 24'(drv[c]);
        end
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        repeat (3) tick();
        for (int c = 0; c < NCH; c++) audio_bus[c] = 24'(8000000 - c);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        chk("overrun_pulse", 32'(overrun), 32'd1);
        chk("overrun_busy", 32'(busy), 32'd1);
        tick();
        chk("overrun_clear", 32'(overrun), 32'd0);
        repeat (3) tick();
        chk("overrun_scan_end", 32'(busy), 32'd0);
        model_frame(-1);
        sweep("overrun_data");

        // small peaks: 1 and 0x100 through hold and decay to zero
        zero_drv();
        drv[0] = 1;
        drv[3] = 32'h100;
        run_frame("small_set", -1, 1'b1);
        zero_drv();
        for (int f = 0; f < 6; f++) run_frame("small_decay", -1, 1'b1);

        // back-to-back frames at minimum spacing
        for (int c = 0; c < NCH; c++) drv[c] = rand_sample();
        run_frame("b2b_a", -1, 1'b0);
        for (int c = 0; c < NCH; c++) drv[c] = rand_sample();
        run_frame("b2b_b", -1, 1'b1);

        // reset during channel 3 of a scan
        for (int c = 0; c < NCH; c++) audio_bus[c] = 24'(7000000 + c);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_clip", 32'(clip), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_peak0", 32'(dut.peak_q[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++) drv[c] = rand_sample();
        run_frame("after_rst", -1, 1'b1);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            for (int c = 0; c < NCH; c++) drv[c] = ($urandom_range(0, 2) == 0) ? 0 : rand_sample();
            clear_slot = int'($urandom_range(0, 11));
            if (clear_slot >= NCH) clear_slot = -1;
            run_frame("rand", clear_slot, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/peak_meter.md
# peak_meter

Multi-channel peak meter downstream of the mixer's saturation stage; consumes the post-DSP 24-bit audio bus once per frame and replaces the raw magnitude-to-LED tap. Keeps a per-channel peak with hold and exponential decay. Drives an 8-LED thermometer bar (6 dB per LED) for a selectable channel, plus optional sticky clip flags. Runs in the DSP clock domain and is paced by the frame strobe that also starts the DSP core.

## Interface
- `NUM_CHANNELS`, 8: channels metered.
- `HOLD_FRAMES`, 24000: frames a new peak is held before decay starts; 0 means no hold.
- `DECAY_SHIFT`, 10: per-frame decay is `peak >> DECAY_SHIFT`, with a minimum of 1 when peak is nonzero.
- `clk` input 1: DSP clock.
- `rst` input 1: asynchronous, active-low reset.
- `frame_strobe` input 1: single-cycle pulse, one per audio frame.
- `audio_bus` input `NUM_CHANNELS`x24 signed: post-saturation samples.
- `sel` input `$clog2(NUM_CHANNELS)`: channel shown on `led`.
- `clear_clip` input 1: single-cycle pulse; clears all clip flags.
- `led` output 8: thermometer bar for channel `sel`.
- `clip` output `NUM_CHANNELS`: sticky per-channel clip flags.
- `busy` output 1: scan in progress.
- `overrun` output 1: single-cycle pulse when a strobe arrives while `busy`.

## Operation
- **States:**
  - IDLE: a strobe moves to SCAN, sets channel index = 0, and snapshots `audio_bus` into an internal register. The bus may change afterwards.
  - SCAN: processes one channel per clock.
  - At index `NUM_CHANNELS-1`, returns to IDLE.
- **Magnitude:** `mag = |x|`, saturating, so -8388608 gives 8388607. It is a 23-bit unsigned value.
- **Per-channel update, in priority order:**
  - If `mag > peak[c]`: set `peak = mag` and `hold = HOLD_FRAMES`.
  - Otherwise, if `hold != 0`: decrement `hold`.
  - Otherwise, if `peak != 0`: `peak -= max(peak >> DECAY_SHIFT, 1)`. Saturate at 0 (no wrap).
- **Equal magnitude:** `mag == peak` counts as not greater, so hold is not refreshed.
- **Strobe while busy:** ignored, with no snapshot and no restart. `overrun` pulses for 1 cycle.
- **LED bar:** `led[k] = (peak[sel] >= 2^(15+k))` for k = 0..7.
  - `led[7]` lights at -6 dBFS and above; `led[0]` lights at about -48 dBFS.
  - The output is monotonic: a lit bit implies all lower bits are lit.
- **Reset mid-scan:** all state clears immediately. A scan is never resumed.

## Timing
- **Reset values:**
  - `led` = 0, `clip` = 0, `busy` = 0, `overrun` = 0.
  - All peaks = 0, all hold counters = 0, state = IDLE.
- **Scan timing:**
  - The snapshot is taken on the edge where `frame_strobe` is sampled high (edge t).
  - Channel c is updated on edge t+1+c.
  - `busy` is high after edge t through edge t+`NUM_CHANNELS`.
  - The minimum strobe spacing without overrun is `NUM_CHANNELS`+1 cycles.
- **`led` latency:** registered, one cycle after a change in `peak[sel]` or `sel`.
- **`overrun`:** registered, asserted the cycle after the offending strobe.
- **`clear_clip` with a clip event:** if `clear_clip` lands on the same edge as a clip event for that channel, the set wins.

## Configuration
- `PEAK_METER_CLIP_LATCH_EN` defined:
  - `clip[c]` sets when `mag == 8388607` for channel c during its scan slot, i.e. full scale of either polarity.
  - The flag stays set until `clear_clip`.
- Undefined:
  - `clip` is tied to 0.
  - `clear_clip` is ignored.
  - No clip registers are synthesised.

## Structure
- **Package `meter_pkg`:**
  - `SAMPLE_W` = 24 and `sample_t` (signed 24).
  - `mag_t` (unsigned 23).
  - Function `abs_sat(sample_t) -> mag_t`.
  - Constant `LED_BASE_BIT` = 15.
  - FSM state enum.
- **Sub-module `meter_bar`:** combinational conversion of `mag_t` to the 8-bit thermometer; its output is registered in `peak_meter`.
- **Storage:** peaks and hold counters are register arrays indexed by the scan index. A single shared compare/decay datapath serves all channels.

## Test plan
- Reset, then one strobe with all channels at 0 -> `led` = 0x00 and `clip` = 0. `busy` is high for exactly 8 cycles and `overrun` stays low.
- Channel 2 = 0x400000, `sel` = 2, `HOLD_FRAMES` = 3, `DECAY_SHIFT` = 10, then zero input:
  - `led` = 0xFF, and the peak stays at 0x400000 for 3 frames.
  - On the 4th frame the peak becomes 0x3FF000; `led` stays 0xFF until the peak drops below 0x400000.
- Channel 5 = -8388608 with the macro defined -> peak = 0x7FFFFF and `clip[5]` = 1. A `clear_clip` pulse gives `clip` = 0.
  - Same stimulus with the macro undefined -> `clip` stays 0.
- Strobes 4 cycles apart -> the second strobe gives `overrun` = 1 for one cycle; the scan completes with only first-frame data.
- Peak of 1 with no hold -> becomes 0 after one frame and never goes negative.
  - Input 0x000100 with `DECAY_SHIFT` = 10 -> decays by 1 per frame.
- Assert `rst` low during channel 3 of a scan -> all outputs 0 immediately. The next strobe scans from channel 0.
